// File: rtl/vmu_accumulator.sv
// Purpose : sums `len` signed Q4.14 products from the VMU multiplier into one saturated inner product.
// Latency : last product taken at edge t -> out_valid high after edge t+1; len==0 -> out_valid after the start edge.
// Backpress: result held in DONE until out_valid&out_ready; in_valid beats outside ACC are dropped, start ignored while busy.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   start, len        begin an operation of `len` beats (len sampled with start)
//   in_valid, in_data one signed DATA_W product per valid cycle
//   busy              high from accepted start until result accepted
//   out_valid/out_ready/out_data/out_sat  result handshake, saturated sum, clip flag
module vmu_accumulator #(
  parameter int DATA_W = 19,
  parameter int LEN_W  = 8,
  parameter int ACC_W  = 27
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              last_q, last_d;   // final beat has been summed; clip happens next cycle
  logic [DATA_W-1:0] res_q, res_d;
  logic              sat_q, sat_d;

  // ---------------------------------------------------------------------------
  // Shared combinational terms
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0]    in_ext;
  logic [LEN_W:0]      cnt_inc;
  logic                beat_take;
  logic                beat_last;
  logic                handshake;
  logic                start_ok;
  logic                len_zero;
  logic [ACC_W-DATA_W:0] acc_hi;
  logic                fits;
  logic [DATA_W-1:0]   clip_val;

  assign in_ext = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};

  // One extra bit so a count of 2^LEN_W-1 compares cleanly and never wraps.
  assign cnt_inc = {1'b0, cnt_q} + {{LEN_W{1'b0}}, 1'b1};

  // Once the last beat is in, further in_valid beats are ignored while the
  // result is clipped and registered.
  assign beat_take = (state_q == S_ACC) && !last_q && in_valid;
  assign beat_last = beat_take && (cnt_inc == {1'b0, len_q});

  assign handshake = (state_q == S_DONE) && out_ready;

  // A new operation may start from IDLE or in the same cycle the held result
  // is accepted, so back-to-back operations have no idle bubble.
  assign start_ok = start && ((state_q == S_IDLE) || handshake);
  assign len_zero = (len == '0);

  // The sum fits in DATA_W iff every bit from the DATA_W sign bit upward
  // agrees; otherwise the accumulator sign picks the rail.
  assign acc_hi   = acc_q[ACC_W-1:DATA_W-1];
  assign fits     = (&acc_hi) || !(|acc_hi);
  assign clip_val = acc_q[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                   : {1'b0, {(DATA_W-1){1'b1}}};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = len_zero ? S_DONE : S_ACC;
        end
      end
      S_ACC: begin
        if (last_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (handshake) begin
          if (start_ok) begin
            state_d = len_zero ? S_DONE : S_ACC;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      len_q  <= '0;
      last_q <= 1'b0;
      res_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      len_q  <= len_d;
      last_q <= last_d;
      res_q  <= res_d;
      sat_q  <= sat_d;
    end
  end

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    len_d  = len_q;
    last_d = last_q;
    res_d  = res_q;
    sat_d  = sat_q;

    if (start_ok) begin
      len_d  = len;
      acc_d  = '0;
      cnt_d  = '0;
      last_d = 1'b0;
      if (len_zero) begin
        // Empty vector: the result is an exact zero, available next cycle.
        res_d = '0;
        sat_d = 1'b0;
      end
    end else if (beat_take) begin
      acc_d  = acc_q + in_ext;
      cnt_d  = cnt_inc[LEN_W-1:0];
      last_d = beat_last;
    end else if ((state_q == S_ACC) && last_q) begin
      // Clip only the completed sum; the wide accumulator never wraps.
      last_d = 1'b0;
      if (fits) begin
        res_d = acc_q[DATA_W-1:0];
        sat_d = 1'b0;
      end else begin
        res_d = clip_val;
        sat_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_DONE);
    out_data  = res_q;
    out_sat   = sat_q;
  end

endmodule

// File: tb/tb_vmu_accumulator.sv
module tb_vmu_accumulator;

  localparam int DATA_W = 19;
  localparam int LEN_W  = 8;
  localparam int ACC_W  = 27;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sat;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard entries: {sat, data}
  logic [DATA_W:0] sb[$];

  vmu_accumulator #(.DATA_W(DATA_W), .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat)
  );

  always #5 clk = ~clk;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic void push_exp(int d, bit s);
    logic [DATA_W-1:0] dv;
    dv = DATA_W'(d);
    sb.push_back({s, dv});
  endfunction

  // Monitor: handshake happens at the next rising edge when both are high.
  always @(negedge clk) begin
    logic [DATA_W:0] e;
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got data 0x%0h with no expected result queued", out_data);
      end else begin
        e = sb.pop_front();
        check("sb_data", {13'd0, out_data}, {13'd0, e[DATA_W-1:0]});
        check("sb_sat", {31'd0, out_sat}, {31'd0, e[DATA_W]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input int l);
    start = 1'b1;
    len   = LEN_W'(l);
    step();
    start = 1'b0;
  endtask

  task automatic send(input int d);
    in_valid = 1'b1;
    in_data  = DATA_W'(d);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string nm);
    int i;
    i = 0;
    while (!out_valid && i < 20) begin
      step();
      i++;
    end
    check(nm, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("accept_valid_low", {31'd0, out_valid}, 32'd0);
    check("accept_busy_low", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vpat[8];
    int dval;
    rst       = 1'b0;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {13'd0, out_data}, 32'd0);
    check("rst_sat", {31'd0, out_sat}, 32'd0);
    step();
    step();
    rst = 1'b1;
    step();

    // 1: four back-to-back beats of 1.0, one-cycle result latency
    push_exp(65536, 1'b0);
    start_op(4);
    check("t1_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) send(16384);
    check("t1_lat_not_yet", {31'd0, out_valid}, 32'd0);
    step();
    check("t1_lat_valid", {31'd0, out_valid}, 32'd1);
    accept();

    // 2: mixed signs
    push_exp(-12288, 1'b0);
    start_op(3);
    send(-16384);
    send(8192);
    send(-4096);
    wait_out("t2_valid");
    check("t2_data", {13'd0, out_data}, 32'h7D000);
    accept();

    // 3: positive and negative saturation
    push_exp(262143, 1'b1);
    start_op(8);
    for (int i = 0; i < 8; i++) send(65536);
    wait_out("t3p_valid");
    accept();
    push_exp(-262144, 1'b1);
    start_op(8);
    for (int i = 0; i < 8; i++) send(-65536);
    wait_out("t3n_valid");
    accept();

    // 4: gapped input, then held result with ignored start/in_valid
    push_exp(510, 1'b0);
    vpat = '{1, 0, 1, 1, 0, 0, 1, 1};
    start_op(5);
    dval = 100;
    for (int i = 0; i < 8; i++) begin
      if (vpat[i] != 0) begin
        send(dval);
        dval++;
      end else begin
        step();
      end
    end
    wait_out("t4_valid");
    for (int i = 0; i < 5; i++) begin
      start    = (i % 2 == 0);
      len      = 8'd3;
      in_valid = 1'b1;
      in_data  = 19'd999;
      step();
      check("t4_hold_data", {13'd0, out_data}, 32'd510);
      check("t4_hold_busy", {31'd0, busy}, 32'd1);
      check("t4_hold_valid", {31'd0, out_valid}, 32'd1);
    end
    start    = 1'b0;
    in_valid = 1'b0;
    accept();

    // 5: zero-length op, then back-to-back start on the accepting cycle
    push_exp(0, 1'b0);
    start_op(0);
    check("t5_len0_valid", {31'd0, out_valid}, 32'd1);
    push_exp(3, 1'b0);
    out_ready = 1'b1;
    start     = 1'b1;
    len       = 8'd2;
    step();
    out_ready = 1'b0;
    start     = 1'b0;
    check("t5_b2b_busy", {31'd0, busy}, 32'd1);
    check("t5_b2b_valid", {31'd0, out_valid}, 32'd0);
    send(1);
    send(2);
    wait_out("t5_valid");
    accept();

    // 6: asynchronous reset mid-operation
    start_op(4);
    send(1000);
    send(1000);
    rst = 1'b0;
    #1;
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t6_rst_data", {13'd0, out_data}, 32'd0);
    check("t6_rst_sat", {31'd0, out_sat}, 32'd0);
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6_no_valid", {31'd0, out_valid}, 32'd0);
    end
    push_exp(7, 1'b0);
    start_op(1);
    send(7);
    wait_out("t6_valid");
    accept();

    // Maximum length: counter must reach 255 without wrapping
    push_exp(255000, 1'b0);
    start_op(255);
    for (int i = 0; i < 255; i++) send(1000);
    wait_out("tmax_valid");
    accept();

    step();
    step();
    check("sb_drain", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
